// File: rtl/color_pkg.sv
// Shared colour types for the video output path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package color_pkg;

    localparam int RGB_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BLACK       = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t TRANSPARENT = '{r: 8'hFF, g: 8'h00, b: 8'hFF};

endpackage

// File: rtl/goal_flash_ctrl.sv
// Frame-synchronous goal flash sequencer: vsync edge detect, FSM, frame/phase counters.
// Latency: flash_on changes on the clock edge that ends a frame-tick cycle; flash_busy follows the state register.
// Backpressure: none; goal_pulse is a single-cycle request and is never stalled.
module goal_flash_ctrl #(
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_PHASES = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_in,
    input  logic goal_pulse,
    output logic flash_on,
    output logic flash_busy
);

    typedef enum logic [1:0] {IDLE, PENDING, RUN} flash_state_t;

    localparam logic [7:0] LAST_FRAME = 8'(FLASH_FRAMES - 1);
    localparam logic [3:0] LAST_PHASE = 4'(FLASH_PHASES - 1);

    flash_state_t state_q, state_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic [3:0]   phase_cnt_q, phase_cnt_d;
    logic         flash_on_q, flash_on_d;
    logic         vs_hist_q, vs_hist_d;
    logic         frame_tick;

    assign frame_tick = vs_hist_q & ~vsync_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            phase_cnt_q <= '0;
            flash_on_q  <= 1'b0;
            vs_hist_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            flash_on_q  <= flash_on_d;
            vs_hist_q   <= vs_hist_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        phase_cnt_d = phase_cnt_q;
        flash_on_d  = flash_on_q;
        vs_hist_d   = vsync_in;
        case (state_q)
            IDLE: begin
                if (goal_pulse) state_d = PENDING;
            end
            PENDING: begin
                if (frame_tick) begin
                    state_d     = RUN;
                    frame_cnt_d = '0;
                    phase_cnt_d = '0;
                    flash_on_d  = 1'b1;
                end
            end
            RUN: begin
                // A new goal re-arms; flash_on is left alone until the restart tick.
                if (goal_pulse) begin
                    state_d = PENDING;
                end else if (frame_tick) begin
                    if (frame_cnt_q == LAST_FRAME) begin
                        frame_cnt_d = '0;
                        if (phase_cnt_q == LAST_PHASE) begin
                            state_d     = IDLE;
                            phase_cnt_d = '0;
                            flash_on_d  = 1'b0;
                        end else begin
                            phase_cnt_d = phase_cnt_q + 4'd1;
                            flash_on_d  = ~flash_on_q;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flash_on   = flash_on_q;
        flash_busy = (state_q != IDLE);
    end

endmodule

// File: rtl/pixel_compositor.sv
// Per-pixel priority layer mixer with background fallback and goal-flash recolouring.
// Latency: exactly 2 clocks from every input to pix_out/de_out/hsync_out/vsync_out.
// Backpressure: none; one pixel accepted and produced every clock.
module pixel_compositor
    import color_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int FLASH_LAYER  = 0,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_PHASES = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        de_in,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [RGB_W-1:0]            bg_color,
    input  logic [RGB_W-1:0]            flash_color,
    input  logic                        goal_pulse,
    output logic [RGB_W-1:0]            pix_out,
    output logic                        de_out,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic                        flash_busy
);

    logic                        de_s1_q, de_s1_d;
    logic                        hs_s1_q, hs_s1_d;
    logic                        vs_s1_q, vs_s1_d;
    logic [NUM_LAYERS*RGB_W-1:0] color_s1_q, color_s1_d;
    logic [NUM_LAYERS-1:0]       en_s1_q, en_s1_d;
    rgb_t                        bg_s1_q, bg_s1_d;
    rgb_t                        flash_s1_q, flash_s1_d;

    rgb_t pix_q, pix_d;
    logic de_q, hs_q, vs_q;
    logic flash_on;
    logic found;

    goal_flash_ctrl #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .FLASH_PHASES (FLASH_PHASES)
    ) u_flash (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync_in   (vsync_in),
        .goal_pulse (goal_pulse),
        .flash_on   (flash_on),
        .flash_busy (flash_busy)
    );

    always_comb begin
        de_s1_d    = de_in;
        hs_s1_d    = hsync_in;
        vs_s1_d    = vsync_in;
        color_s1_d = layer_color;
        en_s1_d    = layer_en;
        bg_s1_d    = bg_color;
        flash_s1_d = flash_color;
    end

    // Lowest enabled index wins; blanking overrides everything.
    always_comb begin
        pix_d = bg_s1_q;
        found = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (!found && en_s1_q[i]) begin
                found = 1'b1;
                pix_d = (i == FLASH_LAYER && flash_on) ? flash_s1_q
                                                        : color_s1_q[i*RGB_W +: RGB_W];
            end
        end
        if (!de_s1_q) pix_d = BLACK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_s1_q    <= 1'b0;
            hs_s1_q    <= 1'b1;
            vs_s1_q    <= 1'b1;
            color_s1_q <= '0;
            en_s1_q    <= '0;
            bg_s1_q    <= BLACK;
            flash_s1_q <= BLACK;
            pix_q      <= BLACK;
            de_q       <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
        end else begin
            de_s1_q    <= de_s1_d;
            hs_s1_q    <= hs_s1_d;
            vs_s1_q    <= vs_s1_d;
            color_s1_q <= color_s1_d;
            en_s1_q    <= en_s1_d;
            bg_s1_q    <= bg_s1_d;
            flash_s1_q <= flash_s1_d;
            pix_q      <= pix_d;
            de_q       <= de_s1_q;
            hs_q       <= hs_s1_q;
            vs_q       <= vs_s1_q;
        end
    end

    assign pix_out   = pix_q;
    assign de_out    = de_q;
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed plus randomized bench for pixel_compositor against a frame/phase-level reference model.
module tb_pixel_compositor;
    import color_pkg::*;

    localparam int NL        = 4;
    localparam int FF        = 2;
    localparam int FP        = 3;
    localparam int FRAME_LEN = 16;

    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] FOREST  = 24'h228B22;
    localparam logic [23:0] FLASH_C = 24'hFFD700;
    localparam logic [23:0] L0_C    = 24'h123456;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              de_in, hsync_in, vsync_in;
    logic [NL*24-1:0]  layer_color;
    logic [NL-1:0]     layer_en;
    logic [23:0]       bg_color, flash_color;
    logic              goal_pulse;
    logic [23:0]       pix_out;
    logic              de_out, hsync_out, vsync_out, flash_busy;

    always #5 clk = ~clk;

    pixel_compositor #(
        .NUM_LAYERS   (NL),
        .FLASH_LAYER  (0),
        .FLASH_FRAMES (FF),
        .FLASH_PHASES (FP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .layer_color (layer_color),
        .layer_en    (layer_en),
        .bg_color    (bg_color),
        .flash_color (flash_color),
        .goal_pulse  (goal_pulse),
        .pix_out     (pix_out),
        .de_out      (de_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .flash_busy  (flash_busy)
    );

    typedef struct packed {
        logic [23:0] pix;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    localparam exp_t RST_EXP = '{pix: 24'h0, de: 1'b0, hs: 1'b1, vs: 1'b1};

    int   checks = 0;
    int   errors = 0;
    exp_t prev_exp;

    // Reference model: flash progress is tracked as ticks elapsed since the sequence started.
    bit m_pending, m_running, m_on, m_prev_vs;
    int m_k;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] ref_pix();
        if (!de_in) return 24'h0;
        for (int i = 0; i < NL; i++) begin
            if (layer_en[i]) return (i == 0 && m_on) ? flash_color : layer_color[i*24 +: 24];
        end
        return bg_color;
    endfunction

    task automatic compare_outputs(input exp_t e, input bit busy);
        chk("pix", pix_out, e.pix);
        chk("de", 24'(de_out), 24'(e.de));
        chk("hsync", 24'(hsync_out), 24'(e.hs));
        chk("vsync", 24'(vsync_out), 24'(e.vs));
        chk("busy", 24'(flash_busy), 24'(busy));
    endtask

    task automatic step();
        exp_t cur;
        bit   tick;
        if (!rst_n) begin
            m_pending = 0; m_running = 0; m_on = 0; m_prev_vs = 1; m_k = 0;
            @(posedge clk); #1;
            compare_outputs(RST_EXP, 1'b0);
            prev_exp = RST_EXP;
            return;
        end
        tick      = m_prev_vs && !vsync_in;
        m_prev_vs = vsync_in;
        if (goal_pulse) begin
            if (!m_pending) begin
                m_pending = 1;
                m_running = 0;
            end
        end else if (tick) begin
            if (m_pending) begin
                m_pending = 0; m_running = 1; m_k = 0; m_on = 1;
            end else if (m_running) begin
                m_k++;
                if (m_k == FF * FP) begin
                    m_running = 0;
                    m_on      = 0;
                end else begin
                    m_on = ((m_k / FF) % 2) == 0;
                end
            end
        end
        cur.pix = ref_pix();
        cur.de  = de_in;
        cur.hs  = hsync_in;
        cur.vs  = vsync_in;
        @(posedge clk); #1;
        compare_outputs(prev_exp, m_pending || m_running);
        prev_exp = cur;
    endtask

    task automatic rand_pix(input bit bias0);
        layer_color = {$urandom(), $urandom(), $urandom()};
        layer_en    = 4'($urandom_range(0, 15));
        if (bias0 && $urandom_range(0, 1) == 1) layer_en[0] = 1'b1;
        bg_color    = 24'($urandom());
        de_in       = ($urandom_range(0, 3) != 0);
    endtask

    task automatic run_frames(input int n, input int goal_at);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < FRAME_LEN; c++) begin
                vsync_in   = (c >= 2);
                hsync_in   = (c % 8 != 4);
                goal_pulse = (f * FRAME_LEN + c == goal_at);
                rand_pix(1'b1);
                step();
            end
        end
        goal_pulse = 1'b0;
    endtask

    task automatic probe(input bit want_flash, input string tag);
        vsync_in    = 1'b1;
        hsync_in    = 1'b1;
        de_in       = 1'b1;
        layer_en    = 4'b0001;
        layer_color = {72'h0, L0_C};
        bg_color    = 24'h0;
        step();
        step();
        chk(tag, pix_out, want_flash ? FLASH_C : L0_C);
    endtask

    initial begin
        rst_n       = 1'b0;
        de_in       = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        layer_color = '0;
        layer_en    = '0;
        bg_color    = '0;
        flash_color = FLASH_C;
        goal_pulse  = 1'b0;
        prev_exp    = RST_EXP;
        m_prev_vs   = 1;
        repeat (3) step();
        rst_n = 1'b1;

        layer_color = {24'h0, BLUE, RED, 24'h00FF00};
        layer_en    = 4'b0110;
        de_in       = 1'b1;
        step(); step();
        chk("priority", pix_out, RED);

        layer_en = 4'b0000;
        bg_color = FOREST;
        step(); step();
        chk("background", pix_out, FOREST);
        de_in = 1'b0;
        step(); step();
        chk("blank", pix_out, 24'h0);

        for (int c = 0; c < 120; c++) begin
            hsync_in = !(c >= 10 && c < 106);
            vsync_in = !(c >= 50 && c < 53);
            rand_pix(1'b0);
            step();
        end
        hsync_in = 1'b1;
        vsync_in = 1'b1;

        for (int c = 0; c < 200; c++) begin
            hsync_in = ($urandom_range(0, 7) != 0);
            vsync_in = ($urandom_range(0, 15) != 0);
            rand_pix(1'b0);
            step();
        end
        vsync_in = 1'b1;
        step();

        run_frames(1, 5);
        chk("busy_pending", 24'(flash_busy), 24'h1);
        for (int f = 1; f <= 6; f++) begin
            run_frames(1, -1);
            probe(f == 1 || f == 2 || f == 5 || f == 6, "flash_frame");
        end
        chk("busy_last", 24'(flash_busy), 24'h1);
        run_frames(1, -1);
        probe(1'b0, "flash_done");
        chk("busy_done", 24'(flash_busy), 24'h0);

        run_frames(1, 3);
        run_frames(1, -1);
        run_frames(1, -1);
        run_frames(1, -1);
        probe(1'b0, "restart_pre");
        goal_pulse = 1'b1;
        step();
        goal_pulse = 1'b0;
        chk("restart_busy", 24'(flash_busy), 24'h1);
        probe(1'b0, "restart_hold");
        for (int f = 1; f <= 6; f++) begin
            run_frames(1, -1);
            probe(f == 1 || f == 2 || f == 5 || f == 6, "restart_frame");
        end
        run_frames(1, -1);
        chk("restart_done", 24'(flash_busy), 24'h0);

        run_frames(1, 0);
        probe(1'b0, "tick_goal_pending");
        chk("tick_goal_busy", 24'(flash_busy), 24'h1);
        run_frames(1, -1);
        probe(1'b1, "tick_goal_start");

        rst_n = 1'b0;
        de_in = 1'b1;
        step();
        rst_n = 1'b1;
        chk("rst_pix", pix_out, 24'h0);
        chk("rst_busy", 24'(flash_busy), 24'h0);
        probe(1'b0, "post_rst");
        for (int f = 0; f < 3; f++) begin
            run_frames(1, -1);
            probe(1'b0, "post_rst_frame");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_compositor.md
# pixel_compositor

Final per-pixel layer mixer in the video output path. Takes the colour/enable pairs from all sprite renderers (goal flag, player pieces, board tiles, …) for the current x/y. It selects the highest-priority visible layer, falls back to a background colour, and drives the registered pixel to the VGA output. Sync and data-enable are delayed so they stay aligned. The block also runs a frame-synchronous "goal flash" effect that recolours one layer for a fixed number of frames after a goal event.

## Interface
Parameters:
- NUM_LAYERS, 4: number of renderer inputs; index 0 = highest priority.
- FLASH_LAYER, 0: layer index recoloured during flash.
- FLASH_FRAMES, 8: frames per flash phase (on or off), 1..255.
- FLASH_PHASES, 6: total phases per flash sequence, starting with "on"; 1..15.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk, input, 1: pixel clock.
  - rst_n, input, 1: synchronous reset, active low.
- Timing inputs:
  - de_in, input, 1: active-video enable for the current pixel.
  - hsync_in, input, 1: horizontal sync, active low.
  - vsync_in, input, 1: vertical sync, active low.
- Layer and colour inputs:
  - layer_color, input, NUM_LAYERS × rgb_t: per-layer colour.
  - layer_en, input, NUM_LAYERS: per-layer "draw this pixel".
  - bg_color, input, rgb_t: colour used when no layer is enabled.
  - flash_color, input, rgb_t: replacement colour for FLASH_LAYER pixels during an "on" phase.
- Goal event:
  - goal_pulse, input, 1: single-cycle goal event request.
- Outputs:
  - pix_out, output, rgb_t: composited pixel.
  - de_out, output, 1: de_in delayed 2 cycles.
  - hsync_out, output, 1: hsync_in delayed 2 cycles.
  - vsync_out, output, 1: vsync_in delayed 2 cycles.
  - flash_busy, output, 1: high while a flash is pending or running.

## Operation
- Stage 1 registers de/hsync/vsync, layer_color, layer_en and bg_color unchanged.
- Stage 2 selects the output pixel from the stage-1 registers:
  - Winner = lowest index i with layer_en[i] = 1.
  - If no layer is enabled: bg_color.
  - If winner == FLASH_LAYER and flash_on = 1: flash_color instead of layer_color.
  - If the stage-1 de = 0: pix_out = BLACK regardless of layers.
- Frame tick: vsync_in sampled falling edge (1 → 0), detected from a registered copy of vsync_in.
- Flash FSM:
  - IDLE: flash_on = 0. goal_pulse → PENDING.
  - PENDING: flash_on = 0. On frame tick → RUN, with phase_cnt = 0, frame_cnt = 0, flash_on = 1.
  - RUN: each frame tick increments frame_cnt.
    - When frame_cnt reaches FLASH_FRAMES−1: frame_cnt ← 0, phase_cnt++, flash_on toggles.
    - When phase_cnt reaches FLASH_PHASES−1 and its last frame ends: → IDLE, flash_on = 0.
- flash_on only changes on a frame tick, so no mid-frame tearing.
- goal_pulse in PENDING: ignored.
- goal_pulse in RUN: → PENDING. The current flash_on value is held until the next frame tick, at which point the sequence restarts from phase 0 "on".
- goal_pulse coinciding with a frame tick in IDLE: → PENDING. The tick is not used; the flash starts on the following tick.
- flash_busy = (state != IDLE).
- Counter widths: frame_cnt 8 bits, phase_cnt 4 bits. Parameters outside the stated ranges are illegal.

## Timing
- Latency is exactly 2 clocks for every input field to every output, including sync and de. No stalls, no backpressure.
- flash_on transitions are visible on pix_out 2 clocks after the frame-tick cycle's inputs.
- Reset (rst_n = 0 at a clk edge) is honoured in any state, including mid-frame and mid-flash:
  - pix_out = BLACK, de_out = 0, hsync_out = 1, vsync_out = 1.
  - flash_busy = 0, state = IDLE, counters = 0.
  - The vsync edge detector history is set to 1, so an input already low after reset does not create a tick.
- After reset release, valid output appears from the 2nd clock.

## Structure
- Use rgb_t, BLACK and TRANSPARENT from color_pkg. Add the FSM state enum (flash_state_t: IDLE, PENDING, RUN) to color_pkg only if other blocks share it; otherwise keep it local.
- Natural sub-module: goal_flash_ctrl. It contains the vsync edge detect, the FSM and the counters, and outputs flash_on and flash_busy. The top level contains the pipeline registers and the priority mux.

## Test plan
- Priority: layer_en = 4'b0110, layer 1 = RED, layer 2 = BLUE → pix_out = RED 2 clocks later.
- Background: layer_en = 0, bg_color = 24'h228B22 → pix_out = 24'h228B22 with de = 1, and BLACK with de = 0.
- Alignment: drive an hsync low pulse of 96 clocks → hsync_out mirrors it delayed exactly 2 clocks; vsync_out and de_out likewise.
- Flash (FLASH_FRAMES = 2, FLASH_PHASES = 3):
  - goal_pulse mid-frame → flash_busy = 1 immediately.
  - Layer 0 pixels show flash_color for frames 1–2, normal for 3–4, flash_color for 5–6.
  - IDLE and flash_busy = 0 after the 6th tick.
- Restart: goal_pulse during phase 1 → the current colour is held until the next tick, then phase 0 "on" restarts for a full 3 phases.
- Reset mid-flash: rst_n low for 1 clock during RUN → next cycle shows outputs BLACK/0/1/1 and flash_busy = 0; layer pixels are no longer recoloured afterwards.
